// File: rtl/myproject_dot_accum.sv
// Accumulate signed products for one dot product, then round, shift and saturate the sum
// to a signed OUT_WIDTH result. The result is presented on a valid/ready output.
module myproject_dot_accum #(
  parameter int PROD_WIDTH = 26,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 10,
  parameter int MAX_TERMS  = 64
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  out_len_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  // Rounding and clamp constants are one bit wider than the accumulator.
  // The +half step can therefore never wrap.
  localparam logic signed [ACC_WIDTH:0] HALF =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] OMAX =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OMIN =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, ROUND, HOLD} state_t;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic                 sat;
    logic                 len_err;
  } res_t;

  state_t                      state, state_nxt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic        [CNT_W-1:0]     cnt;
  logic                        len_err_q;
  res_t                        res_q, res_d;
  logic                        beat, hs, at_max, done;
  logic signed [ACC_WIDTH:0]   acc_ext, rsum, r;
  logic signed [ACC_WIDTH-1:0] prod_ext;

  assign in_ready = (state == ACCUM);
  assign beat     = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign at_max   = (cnt == CNT_W'(MAX_TERMS - 1));
  assign done     = beat && (in_last || at_max);
  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (done) state_nxt = ROUND;
      ROUND:   state_nxt = HOLD;
      HOLD:    if (hs) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Round half up: add half an LSB, then shift arithmetically (floor).
  always_comb begin
    acc_ext       = {acc[ACC_WIDTH-1], acc};
    rsum          = acc_ext + HALF;
    r             = rsum >>> FRAC_SHIFT;
    res_d.data    = r[OUT_WIDTH-1:0];
    res_d.sat     = 1'b0;
    res_d.len_err = len_err_q;
    if (r > OMAX) begin
      res_d.data = OMAX[OUT_WIDTH-1:0];
      res_d.sat  = 1'b1;
    end else if (r < OMIN) begin
      res_d.data = OMIN[OUT_WIDTH-1:0];
      res_d.sat  = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      len_err_q <= 1'b0;
      res_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        acc <= acc + prod_ext;
        cnt <= cnt + CNT_W'(1);
      end
      // A beat carrying in_last is a proper end, even when it is the MAX_TERMS-th beat.
      if (done) len_err_q <= !in_last;
      if (state == ROUND) begin
        res_q     <= res_d;
        out_valid <= 1'b1;
      end
      if (hs) begin
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
        len_err_q <= 1'b0;
      end
    end
  end

  assign out_data    = res_q.data;
  assign out_sat     = res_q.sat;
  assign out_len_err = res_q.len_err;

endmodule
